// File: rtl/serial_parity_acc.sv
// serial_parity_acc: accumulates the parity of a FRAME_BITS-long serial frame.
// A frame begins with start. bit_valid qualifies each data bit. One cycle after
// the frame completes, parity_valid pulses and parity_out updates.
// Optional feature, macro PARITY_CHECK_EN: the frame has one more bit, the
// received parity bit. It is compared against the accumulated parity, and a
// mismatch sets err.
module serial_parity_acc #(
    parameter int FRAME_BITS = 8,
    parameter bit ODD        = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       bit_in,
    input  logic       bit_valid,
    output logic       busy,
    output logic       parity_out,
    output logic       parity_valid,
    output logic [5:0] bit_cnt,
    output logic [7:0] frame_cnt,
    output logic       err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
`ifdef PARITY_CHECK_EN
        , CHECK = 2'd3
`endif
    } state_t;

    localparam logic [5:0] LAST = 6'(FRAME_BITS - 1);

    state_t state, next_state;
    logic   acc;
    logic   last_bit;
    logic   frame_done;

    // Final data bit accepted. start has priority and discards the bit.
    assign last_bit = (state == ACCUM) && bit_valid && !start && (bit_cnt == LAST);

`ifdef PARITY_CHECK_EN
    assign frame_done = (state == CHECK) && bit_valid && !start;
`else
    assign frame_done = last_bit;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state logic. From every state, start goes to a freshly cleared ACCUM.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (start) next_state = ACCUM;
            ACCUM: begin
                if (start) next_state = ACCUM;
`ifdef PARITY_CHECK_EN
                else if (last_bit) next_state = CHECK;
`else
                else if (last_bit) next_state = DONE;
`endif
            end
`ifdef PARITY_CHECK_EN
            CHECK: begin
                if (start)          next_state = ACCUM;
                else if (bit_valid) next_state = DONE;
            end
`endif
            DONE:    next_state = start ? ACCUM : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Moore outputs decoded from state
    always_comb begin
        busy         = 1'b0;
        parity_valid = 1'b0;
        case (state)
            ACCUM: busy = 1'b1;
`ifdef PARITY_CHECK_EN
            CHECK: busy = 1'b1;
`endif
            DONE:  parity_valid = 1'b1;
            default: ;
        endcase
    end

    // Accumulator and bit counter. start clears both in any state; bits count only in ACCUM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= 1'b0;
            bit_cnt <= '0;
        end else if (start) begin
            acc     <= ODD;
            bit_cnt <= '0;
        end else if (state == ACCUM && bit_valid) begin
            acc     <= acc ^ bit_in;
            bit_cnt <= bit_cnt + 6'd1;
        end
    end

    // Result registers load on entry to DONE, so they are valid during the pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_out <= 1'b0;
            frame_cnt  <= '0;
        end else if (frame_done) begin
`ifdef PARITY_CHECK_EN
            parity_out <= acc;
`else
            parity_out <= acc ^ bit_in;
`endif
            frame_cnt  <= frame_cnt + 8'd1;
        end
    end

`ifdef PARITY_CHECK_EN
    // Mismatch flag. It loads from the received parity bit and stays set until the next start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          err <= 1'b0;
        else if (start)      err <= 1'b0;
        else if (frame_done) err <= bit_in ^ acc;
    end
`else
    assign err = 1'b0;
`endif

endmodule
